// File: rtl/apb_slave_regfile_pkg.sv
// Shared types and constants for the APB test-slave register file.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } apb_slv_state_e;

    localparam logic [11:0] WAIT_OFS  = 12'hFF8;
    localparam logic [11:0] ID_OFS    = 12'hFFC;
    localparam logic [31:0] ID_PREFIX = 32'hA9B0_0000;
    localparam int          WAIT_W    = 4;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle seen by one responder; the master side drives the request.
interface apb_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic [DATA_WIDTH-1:0] pwdata_i;
    logic                  pwrite_i;
    logic                  penable_i;
    logic [1:0]            psel_i;
    logic [DATA_WIDTH-1:0] prdata_o;
    logic                  pready_o;
    logic                  pslverr_o;

    modport master (
        output paddr_i, pwdata_i, pwrite_i, penable_i, psel_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  paddr_i, pwdata_i, pwrite_i, penable_i, psel_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_slave_regfile_regbank.sv
// Data register storage: one synchronous write port, one combinational read port.
module apb_slv_regbank #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    // Clear every register on reset, otherwise store the committed write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB responder serving data registers, a wait-state register and an ID register
// inside a 4 KB window; inserts programmable wait states and flags bad accesses.
module apb_slave_regfile
    import apb_slv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0001_F000,
    parameter int                    SEL_IDX    = 0,
    parameter int                    NUM_REGS   = 16,
    parameter logic [WAIT_W-1:0]     WAIT_RST   = '0
) (
    input logic                clk,
    input logic                rst,
    apb_slave_regfile_if.slave bus
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [11:0]           DATA_END = 12'(4 * NUM_REGS);
    localparam logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(ID_PREFIX | 32'(SEL_IDX));

    apb_slv_state_e        state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic [WAIT_W-1:0]     cnt_q;
    logic [WAIT_W-1:0]     wait_q;

    logic                  sel;
    logic                  unused_psel;
    logic [ADDR_WIDTH-1:0] dec_addr;
    logic                  dec_wr;
    logic [11:0]           dec_ofs;
    logic                  is_data;
    logic                  is_wait;
    logic                  is_id;
    logic                  dec_err;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [IDX_W-1:0]      bank_idx;
    logic                  bank_we;
    logic [DATA_WIDTH-1:0] bank_rdata;

    assign sel         = bus.psel_i[SEL_IDX];
    assign unused_psel = ^bus.psel_i;

    // Decode the live request while idle, the latched one once a transfer is under way.
    always_comb begin
        dec_addr = (state_q == IDLE) ? bus.paddr_i  : addr_q;
        dec_wr   = (state_q == IDLE) ? bus.pwrite_i : wr_q;
        dec_ofs  = dec_addr[11:0];
        is_data  = (dec_ofs < DATA_END);
        is_wait  = (dec_ofs == WAIT_OFS);
        is_id    = (dec_ofs == ID_OFS);
        dec_err  = (dec_addr[1:0] != 2'b00)
                || (dec_addr[ADDR_WIDTH-1:12] != BASE_ADDR[ADDR_WIDTH-1:12])
                || !(is_data || is_wait || is_id)
                || (is_id && dec_wr);
        bank_idx = dec_ofs[IDX_W+1:2];
        rd_val   = '0;
        if (!dec_err && !dec_wr) begin
            if (is_data) begin
                rd_val = bank_rdata;
            end else if (is_wait) begin
                rd_val = {{(DATA_WIDTH-WAIT_W){1'b0}}, wait_q};
            end else begin
                rd_val = ID_VALUE;
            end
        end
    end

    assign bank_we = (state_q == RESP) && wr_q && !err_q && is_data;

    apb_slv_regbank #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_regbank (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we),
        .waddr (bank_idx),
        .wdata (wdata_q),
        .raddr (bank_idx),
        .rdata (bank_rdata)
    );

    // Transfer FSM with wait counter, WAIT register and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            wait_q        <= WAIT_RST;
            bus.prdata_o  <= '0;
            bus.pready_o  <= 1'b0;
            bus.pslverr_o <= 1'b0;
        end else begin
            bus.prdata_o  <= '0;
            bus.pready_o  <= 1'b0;
            bus.pslverr_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel && !bus.penable_i) begin
                        addr_q  <= bus.paddr_i;
                        wr_q    <= bus.pwrite_i;
                        wdata_q <= bus.pwdata_i;
                        err_q   <= dec_err;
                        cnt_q   <= wait_q;
                        if (wait_q == '0) begin
                            state_q       <= RESP;
                            bus.pready_o  <= 1'b1;
                            bus.pslverr_o <= dec_err;
                            bus.prdata_o  <= rd_val;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!sel) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - WAIT_W'(1);
                        if (cnt_q == WAIT_W'(1)) begin
                            state_q       <= RESP;
                            bus.pready_o  <= 1'b1;
                            bus.pslverr_o <= err_q;
                            bus.prdata_o  <= rd_val;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    if (wr_q && !err_q && is_wait) begin
                        wait_q <= wdata_q[WAIT_W-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances share one APB bus; directed and
// random transfers are compared against a behavioural register-file model.
module tb_apb_slave_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pwrite = 1'b0;
    logic        penable = 1'b0;
    logic [1:0]  psel = 2'b00;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [2][16];
    logic [3:0]  m_wait [2];

    logic [1:0]  r_sel;
    logic [31:0] r_base;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    bit          r_wr;
    int          r_kind;

    always #5 clk = ~clk;

    apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    assign bus0.paddr_i   = paddr;
    assign bus0.pwdata_i  = pwdata;
    assign bus0.pwrite_i  = pwrite;
    assign bus0.penable_i = penable;
    assign bus0.psel_i    = psel;
    assign bus1.paddr_i   = paddr;
    assign bus1.pwdata_i  = pwdata;
    assign bus1.pwrite_i  = pwrite;
    assign bus1.penable_i = penable;
    assign bus1.psel_i    = psel;

    apb_slave_regfile #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (32'h0001_F000),
        .SEL_IDX    (0),
        .NUM_REGS   (16),
        .WAIT_RST   (4'd0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    apb_slave_regfile #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (32'h0002_F000),
        .SEL_IDX    (1),
        .NUM_REGS   (16),
        .WAIT_RST   (4'd2)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic modelReset();
        for (int k = 0; k < 16; k++) begin
            m_regs[0][k] = '0;
            m_regs[1][k] = '0;
        end
        m_wait[0] = 4'd0;
        m_wait[1] = 4'd2;
    endtask

    task automatic modelAccess(input bit inst, input logic [31:0] addr, input bit wr,
                               input logic [31:0] wd, output bit e_err,
                               output logic [31:0] e_rd, output int e_lat);
        logic [31:0] base;
        logic [31:0] ofs;
        base  = inst ? 32'h0002_F000 : 32'h0001_F000;
        ofs   = addr - base;
        e_lat = 32'(m_wait[inst]);
        e_err = 1'b0;
        e_rd  = '0;
        if (addr[1:0] != 2'b00 || addr < base || addr >= base + 32'd4096) begin
            e_err = 1'b1;
        end else if (ofs < 32'd64) begin
            if (wr) m_regs[inst][ofs[5:2]] = wd;
            else    e_rd = m_regs[inst][ofs[5:2]];
        end else if (ofs == 32'hFF8) begin
            if (wr) m_wait[inst] = wd[3:0];
            else    e_rd = {28'd0, m_wait[inst]};
        end else if (ofs == 32'hFFC) begin
            if (wr) e_err = 1'b1;
            else    e_rd = 32'hA9B0_0000 | {31'd0, inst};
        end else begin
            e_err = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] addr, input bit wr,
                                 input logic [31:0] wd, output int lat, output logic [31:0] rd,
                                 output bit err, output bit other);
        bit use1;
        int c;
        use1 = (sel == 2'b10);
        @(posedge clk); #1;
        psel    = sel;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wd;
        penable = 1'b0;
        other   = use1 ? bus0.pready_o : bus1.pready_o;
        @(posedge clk); #1;
        penable = 1'b1;
        c = 0;
        while (c < 40 && !(use1 ? bus1.pready_o : bus0.pready_o)) begin
            other |= use1 ? bus0.pready_o : bus1.pready_o;
            @(posedge clk); #1;
            c++;
        end
        other |= use1 ? bus0.pready_o : bus1.pready_o;
        lat = c;
        rd  = use1 ? bus1.prdata_o : bus0.prdata_o;
        err = use1 ? bus1.pslverr_o : bus0.pslverr_o;
    endtask

    task automatic doXfer(input string tag, input logic [1:0] sel, input logic [31:0] addr,
                          input bit wr, input logic [31:0] wd);
        bit          inst;
        bit          e_err;
        logic [31:0] e_rd;
        int          e_lat;
        int          lat;
        logic [31:0] rd;
        bit          err;
        bit          other;
        inst = (sel == 2'b10);
        modelAccess(inst, addr, wr, wd, e_err, e_rd, e_lat);
        applyStimulus(sel, addr, wr, wd, lat, rd, err, other);
        checkOutput({tag, ".lat"}, 32'(lat), 32'(e_lat));
        checkOutput({tag, ".err"}, {31'd0, err}, {31'd0, e_err});
        if (!wr) checkOutput({tag, ".rdata"}, rd, e_rd);
        checkOutput({tag, ".other"}, {31'd0, other}, 32'd0);
    endtask

    initial begin
        $display("[TB] start");
        modelReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.pready0",  {31'd0, bus0.pready_o},  32'd0);
        checkOutput("rst.pslverr0", {31'd0, bus0.pslverr_o}, 32'd0);
        checkOutput("rst.prdata0",  bus0.prdata_o,           32'd0);
        checkOutput("rst.pready1",  {31'd0, bus1.pready_o},  32'd0);
        checkOutput("rst.pslverr1", {31'd0, bus1.pslverr_o}, 32'd0);
        checkOutput("rst.prdata1",  bus1.prdata_o,           32'd0);
        rst = 1'b0;

        doXfer("zw.write", 2'b01, 32'h0001_F004, 1'b1, 32'hDEAD_BEEF);
        doXfer("zw.read",  2'b01, 32'h0001_F004, 1'b0, 32'h0);

        doXfer("ws.setwait", 2'b01, 32'h0001_FFF8, 1'b1, 32'd3);
        doXfer("ws.read",    2'b01, 32'h0001_F000, 1'b0, 32'h0);
        doXfer("ws.readwait", 2'b01, 32'h0001_FFF8, 1'b0, 32'h0);

        doXfer("err.misalign", 2'b01, 32'h0001_F002, 1'b0, 32'h0);
        doXfer("err.idwrite",  2'b01, 32'h0001_FFFC, 1'b1, 32'h5555_AAAA);
        doXfer("err.idread",   2'b01, 32'h0001_FFFC, 1'b0, 32'h0);
        doXfer("err.unmapped", 2'b01, 32'h0001_F800, 1'b0, 32'h0);

        doXfer("i1.wrongsel", 2'b01, 32'h0002_FFFC, 1'b0, 32'h0);
        doXfer("i1.idread",   2'b10, 32'h0002_FFFC, 1'b0, 32'h0);

        doXfer("b2b.write", 2'b01, 32'h0001_F03C, 1'b1, 32'h0BAD_F00D);
        doXfer("b2b.read",  2'b01, 32'h0001_F03C, 1'b0, 32'h0);
        doXfer("b2b.write1", 2'b10, 32'h0002_F010, 1'b1, 32'h7654_3210);
        doXfer("b2b.read1",  2'b10, 32'h0002_F010, 1'b0, 32'h0);

        @(posedge clk); #1;
        psel    = 2'b01;
        paddr   = 32'h0001_F014;
        pwrite  = 1'b1;
        pwdata  = 32'h1234_5678;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort.noready", {31'd0, bus0.pready_o}, 32'd0);
        psel    = 2'b00;
        penable = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort.idle", {31'd0, bus0.pready_o}, 32'd0);
        doXfer("abort.readback", 2'b01, 32'h0001_F014, 1'b0, 32'h0);

        for (int i = 0; i < 24; i++) begin
            r_sel  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            r_base = (r_sel == 2'b10) ? 32'h0002_F000 : 32'h0001_F000;
            r_kind = int'($urandom_range(0, 9));
            r_wr   = ($urandom_range(0, 1) == 1);
            r_wd   = $urandom;
            if (r_kind < 6) begin
                r_addr = r_base + 32'(4 * $urandom_range(0, 15));
            end else if (r_kind == 6) begin
                r_addr = r_base + 32'hFF8;
                r_wd   = (r_wd & 32'hFFFF_FFF0) | 32'($urandom_range(0, 3));
            end else if (r_kind == 7) begin
                r_addr = r_base + 32'hFFC;
            end else if (r_kind == 8) begin
                r_addr = r_base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            end else begin
                r_addr = r_base + 32'h100 + 32'(4 * $urandom_range(0, 100));
            end
            doXfer($sformatf("rnd%0d", i), r_sel, r_addr, r_wr, r_wd);
        end

        doXfer("rst.setwait", 2'b01, 32'h0001_FFF8, 1'b1, 32'd3);
        doXfer("rst.prewrite", 2'b01, 32'h0001_F008, 1'b1, 32'hCAFE_F00D);
        @(posedge clk); #1;
        psel    = 2'b01;
        paddr   = 32'h0001_F008;
        pwrite  = 1'b1;
        pwdata  = 32'h1111_2222;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        psel    = 2'b00;
        penable = 1'b0;
        modelReset();
        checkOutput("midrst.pready",  {31'd0, bus0.pready_o},  32'd0);
        checkOutput("midrst.pslverr", {31'd0, bus0.pslverr_o}, 32'd0);
        checkOutput("midrst.prdata",  bus0.prdata_o,           32'd0);
        doXfer("midrst.reg",   2'b01, 32'h0001_F008, 1'b0, 32'h0);
        doXfer("midrst.reg0",  2'b01, 32'h0001_F004, 1'b0, 32'h0);
        doXfer("midrst.wait0", 2'b01, 32'h0001_FFF8, 1'b0, 32'h0);
        doXfer("midrst.wait1", 2'b10, 32'h0002_FFF8, 1'b0, 32'h0);

        @(posedge clk); #1;
        psel    = 2'b00;
        penable = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

- APB responder that sits on one `psel` line of the AXI-to-APB bridge's APB master port.
- Decodes a 4 KB window at `BASE_ADDR` and serves a bank of read/write data registers, a wait-state control register and a read-only ID register.
- Inserts a programmable number of wait states and flags illegal accesses with `pslverr`.
- Two instances (`SEL_IDX` 0/1, bases `0x0001_F000` / `0x0002_F000`) form the bridge's test slave subsystem.

## Interface
- `ADDR_WIDTH`, 32: APB address width.
- `DATA_WIDTH`, 32: APB data width.
- `BASE_ADDR`, `32'h0001_F000`: start of the 4 KB window; must be 4 KB aligned.
- `SEL_IDX`, 0: which `psel_i` bit selects this slave (0 or 1).
- `NUM_REGS`, 16: number of data registers, at offsets `0x000..4*(NUM_REGS-1)`; range 1..64.
- `WAIT_RST`, 0: reset value of the wait register (0..15).

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `paddr_i` in `ADDR_WIDTH`: APB address.
- `pwdata_i` in `DATA_WIDTH`: write data.
- `pwrite_i` in 1: 1 = write.
- `penable_i` in 1: access phase.
- `psel_i` in 2: slave selects; only bit `SEL_IDX` is used.
- `prdata_o` out `DATA_WIDTH`: read data, valid while `pready_o` = 1.
- `pready_o` out 1: transfer completes this cycle.
- `pslverr_o` out 1: error; valid while `pready_o` = 1.

## Operation
- Let `sel` = `psel_i[SEL_IDX]` and `ofs` = `paddr_i[11:0]`.
- **Address map:**
  - Data regs: RW, reset 0.
  - `0xFF8` WAIT: RW; bits [3:0] hold the wait count; upper bits read 0.
  - `0xFFC` ID: RO, value `32'hA9B0_0000 | SEL_IDX`.
- **Error conditions**, `pslverr` = 1: `paddr_i[1:0]` ≠ 0; `paddr_i[ADDR_WIDTH-1:12]` ≠ `BASE_ADDR[ADDR_WIDTH-1:12]`; unmapped `ofs`; write to ID.
  - On error: no register changes and `prdata_o` = 0.
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - On a setup phase (`sel` & !`penable_i`), latch addr, write, wdata and the error flag, and load `cnt` = WAIT[3:0].
  - If WAIT = 0, go to RESP; else go to WAIT.
- **WAIT:**
  - Decrement `cnt`; when `cnt` = 1, go to RESP.
  - If `sel` drops (protocol violation), go to IDLE with no side effects.
- **RESP:**
  - `pready_o` = 1 for exactly one cycle.
  - Writes commit at the end of this cycle; reads present data captured on entry.
  - Then go to IDLE.
- `prdata_o`, `pready_o` and `pslverr_o` are registered and are driven for the RESP cycle only; otherwise they are 0.
- A write to WAIT affects the next transfer, not the current one.
- Writes are full-word; there is no strobe support.
- Selects other than bit `SEL_IDX` are ignored entirely.

## Timing
- **Reset:** FSM = IDLE, `prdata_o` = 0, `pready_o` = 0, `pslverr_o` = 0, data regs = 0, WAIT = `WAIT_RST`.
- **Latency:** with setup phase at T0, the first access cycle is T1 and `pready_o` is high at T1+N, where N = WAIT.
  - A zero-wait transfer takes 2 cycles.
- **Back-to-back:** a new setup phase in the cycle after RESP is accepted from IDLE, giving no lost cycle.
- **Read-after-write:** a read issued directly after a write to the same register returns the new data.
- **Reset mid-transfer:**
  - Returns the FSM to IDLE and clears all outputs next cycle.
  - A write in flight is dropped.
- **Setup phase during RESP:** not possible under legal APB; the FSM completes RESP and ignores it.

## Structure
- **Package `apb_slv_pkg`:**
  - state enum `apb_slv_state_e` (IDLE, WAIT, RESP);
  - `WAIT_OFS` = `12'hFF8`, `ID_OFS` = `12'hFFC`, `ID_PREFIX` = `32'hA9B0_0000`;
  - `WAIT_W` = 4.
- **Sub-module `apb_slv_regbank`:** `NUM_REGS`×`DATA_WIDTH` storage with one write port and one read port (synchronous write, combinational read).
- **Top level:** FSM, decode/error logic, wait counter and output registers.

## Test plan
- **Zero-wait RW:** reset, write `0xDEADBEEF` to `0x0001_F004`, read it back → `pready_o` at T1 both times, `prdata_o` = `0xDEADBEEF`, `pslverr_o` = 0.
- **Wait states:** write 3 to `0x0001_FFF8`, then read `0x0001_F000` → `pready_o` low for 3 access cycles, high on the 4th, `prdata_o` = 0.
- **Errors:**
  - Read `0x0001_F002` → `pslverr_o` = 1, `prdata_o` = 0.
  - Write `0x0001_FFFC` → `pslverr_o` = 1, ID unchanged (reads `0xA9B0_0000`).
  - Read `0x0001_F800` → `pslverr_o` = 1.
- **Instance 1 decode:** `SEL_IDX` = 1, `BASE_ADDR` = `0x0002_F000`; access with `psel_i` = `2'b01` → no response; read ID with `psel_i` = `2'b10` → `0xA9B0_0001`.
- **Back-to-back and abort:**
  - Consecutive write then read with no idle cycle → correct data, no stall.
  - Drop `psel_i` mid-WAIT → FSM returns to IDLE and the register is unchanged.
- **Reset mid-transfer:** assert `rst` during WAIT of a write → outputs 0 next cycle, register = 0, WAIT = `WAIT_RST`.
